// File: rtl/calc_seq_pkg.sv
// calc_seq_pkg
// Shared types and constants for the calculator command sequencer.
//   OP_W    : width of the {btnl,btnc,btnr} op select
//   DW      : width of operand / led data
//   state_t : sequencer states
//   entry_t : one program entry {op, sw, exp}
package calc_seq_pkg;

  localparam int OP_W = 3;
  localparam int DW   = 16;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    SETUP,
    PULSE,
    WAIT,
    CAPT,
    FIN
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [DW-1:0]   sw;
    logic [DW-1:0]   exp;
  } entry_t;

endpackage

// File: rtl/calc_seq_mem.sv
// calc_seq_mem
// Program register file for calc_seq: DEPTH entries, synchronous write,
// combinational read. The expected-value column only exists when
// CALC_SEQ_CHECK_EN is defined; otherwise rd_data.exp reads as 0.
// Ports:
//   clk      in  system clock
//   we       in  write strobe (already qualified by the caller)
//   wr_addr  in  write address
//   wr_data  in  entry to store
//   rd_addr  in  read address
//   rd_data  out entry at rd_addr
module calc_seq_mem
  import calc_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  entry_t        wr_data,
  input  logic [AW-1:0] rd_addr,
  output entry_t        rd_data
);

  logic [OP_W-1:0] op_mem [DEPTH];
  logic [DW-1:0]   sw_mem [DEPTH];

  // Program storage is deliberately not reset: the contents survive a
  // sequencer reset so a program can be rerun after an abort.
  always_ff @(posedge clk) begin
    if (we && (int'(wr_addr) < DEPTH)) begin
      op_mem[wr_addr] <= wr_data.op;
      sw_mem[wr_addr] <= wr_data.sw;
    end
  end

`ifdef CALC_SEQ_CHECK_EN
  logic [DW-1:0] exp_mem [DEPTH];

  // Expected-led column, only needed when the comparator exists.
  always_ff @(posedge clk) begin
    if (we && (int'(wr_addr) < DEPTH)) begin
      exp_mem[wr_addr] <= wr_data.exp;
    end
  end

  always_comb begin
    rd_data     = '0;
    rd_data.op  = op_mem[rd_addr];
    rd_data.sw  = sw_mem[rd_addr];
    rd_data.exp = exp_mem[rd_addr];
  end
`else
  logic unused_wr_exp;
  assign unused_wr_exp = ^wr_data.exp;

  always_comb begin
    rd_data    = '0;
    rd_data.op = op_mem[rd_addr];
    rd_data.sw = sw_mem[rd_addr];
  end
`endif

endmodule

// File: rtl/calc_seq.sv
// calc_seq
// Autonomous command sequencer for the calculator. On start it holds the
// calculator in reset (btnu), then for each program entry drives sw and
// {btnl,btnc,btnr}, pulses btnd, waits SETTLE cycles and captures led_in.
// Optional macro: CALC_SEQ_CHECK_EN builds the led-vs-expected comparator
// (err_cnt / first_fail); without it those outputs are tied to 0.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   load_we/addr/op/sw/exp     program write port (idle only)
//   start, len                 begin a run of len entries (clamped to DEPTH)
//   led_in                     calculator led output
//   sw, btnl, btnc, btnr       operand and op select to the calculator
//   btnu, btnd                 calculator reset / enter strobe
//   busy, done                 run in progress / end-of-run pulse
//   last_led                   led captured for the latest entry
//   err_cnt, first_fail        mismatch count and first mismatching index
module calc_seq
  import calc_seq_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int RST_CYC = 2,
  parameter int SETTLE  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_we,
  input  logic [AW-1:0]   load_addr,
  input  logic [OP_W-1:0] load_op,
  input  logic [DW-1:0]   load_sw,
  input  logic [DW-1:0]   load_exp,
  input  logic            start,
  input  logic [AW:0]     len,
  input  logic [DW-1:0]   led_in,
  output logic [DW-1:0]   sw,
  output logic            btnl,
  output logic            btnc,
  output logic            btnr,
  output logic            btnu,
  output logic            btnd,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   last_led,
  output logic [AW:0]     err_cnt,
  output logic [AW-1:0]   first_fail
);

  localparam int          CNT_MAX = (RST_CYC > SETTLE) ? RST_CYC : SETTLE;
  localparam int          CW      = $clog2(CNT_MAX + 1);
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  state_t        state, state_nxt;
  logic [AW-1:0] idx;
  logic [AW:0]   len_q;
  logic [AW:0]   len_clamped;
  logic [CW-1:0] cnt;
  logic          last_entry;
  logic          run_start;
  logic [AW-1:0] rd_addr;
  entry_t        rd_data;
  entry_t        wr_data;

  assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
  assign last_entry  = ({1'b0, idx} == (len_q - 1'b1));
  assign run_start   = (state == IDLE) && start && (len != '0);

  // sw/op are registered on entry to SETUP, so the RAM is read one entry
  // ahead while in CAPT; that way the new operand is visible in SETUP itself.
  assign rd_addr = (state == CAPT) ? (idx + 1'b1) : idx;

  assign wr_data.op  = load_op;
  assign wr_data.sw  = load_sw;
  assign wr_data.exp = load_exp;

  calc_seq_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we      (load_we && !busy),
    .wr_addr (load_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // State register. The strobes below decode straight from this, so an
  // async reset drops btnd/btnu/busy the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe decode. A zero-length start skips straight to
  // FIN so done still pulses one cycle later.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    btnu      = 1'b0;
    btnd      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? FIN : RST;
        end
      end
      RST: begin
        busy = 1'b1;
        btnu = 1'b1;
        if (cnt == CW'(RST_CYC - 1)) begin
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        busy      = 1'b1;
        state_nxt = PULSE;
      end
      PULSE: begin
        busy      = 1'b1;
        btnd      = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt == CW'(SETTLE - 1)) begin
          state_nxt = CAPT;
        end
      end
      CAPT: begin
        busy      = 1'b1;
        state_nxt = last_entry ? FIN : SETUP;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Dwell counter for RST and WAIT; restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Run bookkeeping and calculator-facing data. sw/op only change on entry
  // to SETUP, so they hold through PULSE, WAIT, CAPT and after FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx                <= '0;
      len_q              <= '0;
      sw                 <= '0;
      {btnl, btnc, btnr} <= '0;
      last_led           <= '0;
    end else begin
      if (run_start) begin
        len_q <= len_clamped;
        idx   <= '0;
      end
      if (state_nxt == SETUP) begin
        sw                 <= rd_data.sw;
        {btnl, btnc, btnr} <= rd_data.op;
      end
      if (state == CAPT) begin
        last_led <= led_in;
        if (!last_entry) begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

`ifdef CALC_SEQ_CHECK_EN
  logic [DW-1:0] exp_q;

  // Expected value travels with the entry, since the RAM read port has
  // already moved on to the next entry by the time CAPT compares.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q      <= '0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else begin
      if (run_start) begin
        err_cnt    <= '0;
        first_fail <= '0;
      end
      if (state_nxt == SETUP) begin
        exp_q <= rd_data.exp;
      end
      if ((state == CAPT) && (led_in != exp_q)) begin
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + 1'b1;
        end
        if (err_cnt == '0) begin
          first_fail <= idx;
        end
      end
    end
  end
`else
  logic unused_rd_exp;
  assign unused_rd_exp = ^rd_data.exp;
  assign err_cnt       = '0;
  assign first_fail    = '0;
`endif

endmodule

// File: tb/tb_calc_seq.sv
// tb_calc_seq
// Self-checking bench for calc_seq. A tiny calculator stand-in accumulates
// led += sw on each btnd (cleared by btnu). Expected per-cycle strobes,
// operands, captured led and mismatch bookkeeping come from a reference
// model built on the sequencer's timing rules and plain running sums.
// Honours CALC_SEQ_CHECK_EN for err_cnt / first_fail expectations.
module tb_calc_seq;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int RST_CYC = 2;
  localparam int SETTLE  = 1;
  localparam int PER     = 3 + SETTLE;

  logic          clk;
  logic          rst_n;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [2:0]    load_op;
  logic [15:0]   load_sw;
  logic [15:0]   load_exp;
  logic          start;
  logic [AW:0]   len;
  logic [15:0]   led;
  logic [15:0]   sw;
  logic          btnl, btnc, btnr, btnu, btnd, busy, done;
  logic [15:0]   last_led;
  logic [AW:0]   err_cnt;
  logic [AW-1:0] first_fail;

  int checks;
  int errors;

  logic [2:0]  prog_op  [DEPTH];
  logic [15:0] prog_sw  [DEPTH];
  logic [15:0] prog_exp [DEPTH];

  logic [15:0] m_led;
  int          m_err;
  int          m_ff;

  typedef struct {
    int run_len;
    int exp_pulses;
    int exp_btnu;
    int exp_done;
  } vec_t;

  vec_t vecs[7];

  calc_seq #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .RST_CYC (RST_CYC),
    .SETTLE  (SETTLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_we    (load_we),
    .load_addr  (load_addr),
    .load_op    (load_op),
    .load_sw    (load_sw),
    .load_exp   (load_exp),
    .start      (start),
    .len        (len),
    .led_in     (led),
    .sw         (sw),
    .btnl       (btnl),
    .btnc       (btnc),
    .btnr       (btnr),
    .btnu       (btnu),
    .btnd       (btnd),
    .busy       (busy),
    .done       (done),
    .last_led   (last_led),
    .err_cnt    (err_cnt),
    .first_fail (first_fail)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Calculator stand-in: btnu clears, btnd adds the current operand.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else if (btnu) begin
      led <= '0;
    end else if (btnd) begin
      led <= led + sw;
    end
  end

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // One comparison: bumps counters and reports on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Write one program entry while idle and mirror it in the bench copy.
  task automatic loadEntry(input int addr, input logic [2:0] op,
                           input logic [15:0] swv, input logic [15:0] expv);
    @(negedge clk);
    load_we   = 1'b1;
    load_addr = AW'(addr);
    load_op   = op;
    load_sw   = swv;
    load_exp  = expv;
    prog_op[addr]  = op;
    prog_sw[addr]  = swv;
    prog_exp[addr] = expv;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  // Reference model for one run of n entries: running sum of operands and
  // comparison of each partial sum against the entry's expected value.
  task automatic computeModel(input int n);
    int err;
    int ff;
    logic [15:0] acc;
    if (n == 0) return;
    acc = '0;
    err = 0;
    ff  = 0;
    for (int k = 0; k < n; k++) begin
      acc = acc + prog_sw[k];
      if (acc != prog_exp[k]) begin
        if (err == 0) ff = k;
        err++;
      end
    end
    m_led = acc;
`ifdef CALC_SEQ_CHECK_EN
    m_err = err;
    m_ff  = ff;
`else
    m_err = 0;
    m_ff  = 0;
`endif
  endtask

  // Start a run and watch every cycle until done. Each cycle is held against
  // the expected timeline (RST_CYC btnu cycles, then PER cycles per entry
  // with btnd in the second, then done). poke_cyc>0 fires a start+write
  // attempt while busy; wr_with_start rewrites entry 0 in the start cycle.
  task automatic applyStimulus(input int run_len, input int poke_cyc,
                               input bit wr_with_start,
                               output int done_cyc, output int n_pulse,
                               output int n_btnu, output int bad_cyc);
    int n, fin, k, ph;
    logic e_btnu, e_btnd, e_busy, e_done, chk_data;
    @(negedge clk);
    if (wr_with_start) begin
      load_we     = 1'b1;
      load_addr   = '0;
      load_op     = 3'($urandom);
      load_sw     = 16'($urandom);
      load_exp    = load_sw;
      prog_op[0]  = load_op;
      prog_sw[0]  = load_sw;
      prog_exp[0] = load_exp;
    end
    start = 1'b1;
    len   = (AW+1)'(run_len);
    @(negedge clk);
    start   = 1'b0;
    load_we = 1'b0;
    n   = (run_len > DEPTH) ? DEPTH : run_len;
    fin = (n == 0) ? 1 : RST_CYC + n * PER + 1;
    computeModel(n);
    done_cyc = -1;
    n_pulse  = 0;
    n_btnu   = 0;
    bad_cyc  = 0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (btnd) n_pulse++;
      if (btnu) n_btnu++;
      e_btnu = 1'b0; e_btnd = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      chk_data = 1'b0;
      k = 0; ph = 0;
      if (cyc > fin) begin
        bad_cyc++;
      end else begin
        if (cyc == fin) begin
          e_done = 1'b1;
        end else if (cyc <= RST_CYC) begin
          e_btnu = 1'b1;
          e_busy = 1'b1;
        end else begin
          k  = (cyc - RST_CYC - 1) / PER;
          ph = (cyc - RST_CYC - 1) % PER;
          e_busy   = 1'b1;
          e_btnd   = (ph == 1);
          chk_data = 1'b1;
        end
        if (btnu !== e_btnu || btnd !== e_btnd || busy !== e_busy ||
            done !== e_done) bad_cyc++;
        else if (chk_data && (sw !== prog_sw[k] ||
                 {btnl, btnc, btnr} !== prog_op[k])) bad_cyc++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == poke_cyc) begin
        load_we   = 1'b1;
        load_addr = '0;
        load_op   = ~prog_op[0];
        load_sw   = ~prog_sw[0];
        load_exp  = 16'($urandom);
        start     = 1'b1;
        len       = (AW+1)'(1);
      end else begin
        load_we = 1'b0;
        start   = 1'b0;
      end
      @(negedge clk);
    end
    load_we = 1'b0;
    start   = 1'b0;
  endtask

  // Fill the whole program with random operands; roughly half the expected
  // values are the true running sum, the rest random.
  task automatic loadRandomProgram();
    logic [15:0] acc;
    logic [15:0] swv;
    acc = '0;
    for (int k = 0; k < DEPTH; k++) begin
      swv = 16'($urandom);
      acc = acc + swv;
      loadEntry(k, 3'($urandom_range(0, 7)), swv,
                ($urandom_range(0, 1) == 1) ? acc : 16'($urandom));
    end
  endtask

  task automatic checkRunResult(input string tag);
    checkOutput({tag, "_last_led"}, 32'(last_led), 32'(m_led));
    checkOutput({tag, "_err_cnt"}, 32'(err_cnt), 32'(m_err));
    checkOutput({tag, "_first_fail"}, 32'(first_fail), 32'(m_ff));
  endtask

  initial begin
    int dc, np, nb, bad;
    bit seen;
    checks    = 0;
    errors    = 0;
    m_led     = '0;
    m_err     = 0;
    m_ff      = 0;
    rst_n     = 1'b0;
    load_we   = 1'b0;
    load_addr = '0;
    load_op   = '0;
    load_sw   = '0;
    load_exp  = '0;
    start     = 1'b0;
    len       = '0;

    vecs[0] = '{1, 1, RST_CYC, 7};
    vecs[1] = '{3, 3, RST_CYC, 15};
    vecs[2] = '{0, 0, 0, 1};
    vecs[3] = '{5, 5, RST_CYC, 23};
    vecs[4] = '{16, 16, RST_CYC, 67};
    vecs[5] = '{17, 16, RST_CYC, 67};
    vecs[6] = '{31, 16, RST_CYC, 67};

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_done", 32'(done), 32'(0));
    checkOutput("rst_btnu_btnd", 32'({btnu, btnd}), 32'(0));
    checkOutput("rst_sw_op", 32'({sw, btnl, btnc, btnr}), 32'(0));
    checkOutput("rst_last_led", 32'(last_led), 32'(0));
    checkOutput("rst_err", 32'({err_cnt, first_fail}), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic three-entry run");
    loadEntry(0, 3'b011, 16'h1234, 16'h1234);
    loadEntry(1, 3'b010, 16'h0ff0, 16'h2224);
    loadEntry(2, 3'b000, 16'h324f, 16'h5473);
    applyStimulus(3, 0, 1'b0, dc, np, nb, bad);
    checkOutput("basic_done_cyc", 32'(dc), 32'(15));
    checkOutput("basic_pulses", 32'(np), 32'(3));
    checkOutput("basic_btnu_cycles", 32'(nb), 32'(2));
    checkOutput("basic_trace", 32'(bad), 32'(0));
    checkOutput("basic_last_led", 32'(last_led), 32'h5473);
    checkOutput("basic_err_cnt", 32'(err_cnt), 32'(0));

    $display("[TB] capture and check run");
    loadEntry(0, 3'b000, 16'h0001, 16'h0001);
    loadEntry(1, 3'b000, 16'h0002, 16'h0003);
    loadEntry(2, 3'b000, 16'h0003, 16'h0007);
    applyStimulus(3, 0, 1'b0, dc, np, nb, bad);
    checkOutput("chk_trace", 32'(bad), 32'(0));
    checkOutput("chk_last_led", 32'(last_led), 32'h0006);
`ifdef CALC_SEQ_CHECK_EN
    checkOutput("chk_err_cnt", 32'(err_cnt), 32'(1));
    checkOutput("chk_first_fail", 32'(first_fail), 32'(2));
`else
    checkOutput("chk_err_cnt", 32'(err_cnt), 32'(0));
    checkOutput("chk_first_fail", 32'(first_fail), 32'(0));
`endif

    $display("[TB] zero-length run");
    applyStimulus(0, 0, 1'b0, dc, np, nb, bad);
    checkOutput("len0_done_cyc", 32'(dc), 32'(1));
    checkOutput("len0_strobes", 32'(np + nb), 32'(0));
    checkOutput("len0_last_led", 32'(last_led), 32'h0006);

    $display("[TB] start and write while busy");
    applyStimulus(3, 5, 1'b0, dc, np, nb, bad);
    checkOutput("guard_done_cyc", 32'(dc), 32'(15));
    checkOutput("guard_pulses", 32'(np), 32'(3));
    applyStimulus(3, 0, 1'b0, dc, np, nb, bad);
    checkOutput("guard_rerun_trace", 32'(bad), 32'(0));
    checkOutput("guard_rerun_led", 32'(last_led), 32'h0006);

    $display("[TB] reset during PULSE");
    @(negedge clk);
    start = 1'b1;
    len   = (AW+1)'(3);
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (btnd) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("abort_reached_pulse", 32'(seen), 32'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("abort_btnd", 32'(btnd), 32'(0));
    checkOutput("abort_busy", 32'(busy), 32'(0));
    checkOutput("abort_btnu", 32'(btnu), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_idle_busy", 32'(busy | done), 32'(0));
    checkOutput("abort_err_cnt", 32'(err_cnt), 32'(0));
    checkOutput("abort_last_led", 32'(last_led), 32'(0));
    m_led = '0;
    m_err = 0;
    m_ff  = 0;

    $display("[TB] randomized program, table of run lengths");
    for (int r = 0; r < 2; r++) begin
      loadRandomProgram();
      for (int v = 0; v < 7; v++) begin
        applyStimulus(vecs[v].run_len, 0, 1'b0, dc, np, nb, bad);
        checkOutput($sformatf("vec%0d_done_cyc", v), 32'(dc), 32'(vecs[v].exp_done));
        checkOutput($sformatf("vec%0d_pulses", v), 32'(np), 32'(vecs[v].exp_pulses));
        checkOutput($sformatf("vec%0d_btnu", v), 32'(nb), 32'(vecs[v].exp_btnu));
        checkOutput($sformatf("vec%0d_trace", v), 32'(bad), 32'(0));
        checkRunResult($sformatf("vec%0d", v));
      end
    end

    $display("[TB] write and start in the same idle cycle");
    applyStimulus(2, 0, 1'b1, dc, np, nb, bad);
    checkOutput("samecyc_done_cyc", 32'(dc), 32'(11));
    checkOutput("samecyc_trace", 32'(bad), 32'(0));
    checkRunResult("samecyc");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
